bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Parallel-in/serial-out stage that feeds the serial sequence detectors (e.g. the 1011 detector) one bit per enabled clock. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out on a single-bit line, with a word-boundary marker and a sent-word counter. Runs back-to-back with no bubble when the next word is offered in time.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
CNT_W, 16, width of the sent-word counter
IDLE_LEVEL, 0, value driven on ser_out while no word is in flight

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  reset, asynchronous, active-low
s_valid  input  1  upstream word valid
s_ready  output  1  block can accept a word this cycle
s_data  input  WIDTH  upstream word
bit_en  input  1  bit-rate strobe; a bit is consumed only in cycles with bit_en=1
ser_out  output  1  serial bit to detector input
ser_valid  output  1  ser_out carries a data bit
ser_last  output  1  current bit is the final bit of its word
word_cnt  output  CNT_W  number of fully sent words, wraps

Behaviour:
- Reset (rstn=0, async): ser_out=IDLE_LEVEL, ser_valid=0, ser_last=0, word_cnt=0, state IDLE, shift register and bit counter cleared. Takes effect immediately, mid-word included; the partial word is discarded and not counted.
- States: IDLE (no word), SHIFT (word in flight), PAR (parity bit, only with the optional feature).
- Accept: transfer occurs at a rising edge with s_valid=1 and s_ready=1. s_data is loaded into the shift register and the bit counter is set to WIDTH-1. State becomes SHIFT.
- First-bit latency: the first bit appears on ser_out with ser_valid=1 in the cycle after the accept edge.
- Bit consume: in SHIFT, an edge with bit_en=1 consumes the current bit. The register shifts (MSB_FIRST selects direction) and the counter decrements. With bit_en=0, ser_out, ser_valid and ser_last hold unchanged.
- ser_last=1 while the bit counter is 0 (final data bit), or in PAR.
- s_ready is combinational: s_ready = (state==IDLE) OR (ser_last AND bit_en). Back-to-back words therefore leave no gap cycle: the final bit is consumed at the same edge the new word loads.
- End of word: when the final bit is consumed, word_cnt increments by 1 (modulo 2^CNT_W). If no new word is accepted at that edge, the next state is IDLE, with ser_valid=0 and ser_out=IDLE_LEVEL.
- s_data is ignored when s_ready=0. Upstream must hold s_valid and s_data stable until accepted.
- bit_en arriving while IDLE has no effect.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: after the last data bit, a PAR state drives one extra bit equal to the even-parity XOR of the word, with ser_valid=1 and ser_last=1. ser_last is not asserted on the final data bit. s_ready opens on the parity bit. word_cnt increments when the parity bit is consumed. Each word is WIDTH+1 bits.
- Undefined: no PAR state, WIDTH bits per word, no extra logic.

Test Plan:
- Single word, MSB_FIRST=1: s_data=8'hB0, bit_en=1 constant. Required: ser_out=1,0,1,1,0,0,0,0 on 8 consecutive cycles starting 1 cycle after accept; ser_last high only on the 8th; ser_valid drops after; word_cnt=1; a downstream 1011 detector fires once.
- Back-to-back: 8'hB0 then 8'hFF, s_valid held high. Required: 16 contiguous valid bits with no gap; s_ready pulses high exactly on the 8th bit; word_cnt=2.
- Strobe gating: bit_en high every 3rd cycle, s_data=8'hA5. Required: each bit held 3 cycles; sequence 1,0,1,0,0,1,0,1; total 24 valid cycles.
- Reset mid-word: assert rstn=0 asynchronously after the 3rd bit of 8'hB0. Required: ser_valid=0 and ser_out=0 immediately, without waiting for clk; word_cnt stays 0; s_ready=1 after release.
- LSB_FIRST (MSB_FIRST=0), s_data=8'h0D. Required: 1,0,1,1,0,0,0,0.
- With SER_PARITY_EN, s_data=8'h07. Required: 8 data bits then parity bit 1; ser_last only on the 9th bit; word_cnt increments on the 9th; counter wrap checked with CNT_W=2 after 4 words reads 0.

Source files
------------

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-in / serial-out stage feeding serial sequence detectors.
//            Accepts WIDTH-bit words over a valid/ready handshake and emits
//            them one bit per enabled clock (bit_en), with a word-boundary
//            marker (ser_last) and a wrapping count of fully sent words.
//            Consecutive words stream with no gap cycle when the next word
//            is offered by the time the final bit is consumed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      : data word width in bits (>= 2)
//   MSB_FIRST  : 1 = shift MSB first, 0 = LSB first
//   CNT_W      : width of the sent-word counter
//   IDLE_LEVEL : level driven on ser_out while no word is in flight
// Ports
//   clk       in   clock, all state on rising edge
//   rstn      in   asynchronous active-low reset
//   s_valid   in   upstream word valid
//   s_ready   out  word can be accepted this cycle (combinational)
//   s_data    in   upstream word [WIDTH-1:0]
//   bit_en    in   bit-rate strobe; a bit is consumed only when high
//   ser_out   out  serial data bit
//   ser_valid out  ser_out carries a data bit
//   ser_last  out  current bit is the final bit of its word
//   word_cnt  out  number of fully sent words [CNT_W-1:0], wraps
// Configuration
//   SER_PARITY_EN : when defined, each word is followed by one even-parity
//                   bit (WIDTH+1 bits per word); ser_last and s_ready move
//                   to the parity bit and word_cnt counts on its consumption.
// ============================================================================
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   CNT_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic [CNT_W-1:0] word_cnt
);

  // Bit counter only needs to hold WIDTH-1 (index of remaining bits).
  localparam int BCNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [BCNT_W-1:0] c_bcnt_load = BCNT_W'(WIDTH - 1);
  localparam logic [BCNT_W-1:0] c_bcnt_one  = BCNT_W'(1);
  localparam logic [CNT_W-1:0]  c_wcnt_one  = CNT_W'(1);

  // FSM encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] c_st_par   = 2'd2;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,    state_d;
  logic [WIDTH-1:0]  shreg_q,    shreg_d;
  logic [BCNT_W-1:0] bcnt_q,     bcnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
`ifdef SER_PARITY_EN
  logic              parity_q,   parity_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_cur_bit;   // bit currently presented from the shifter
  logic [WIDTH-1:0] w_shifted;   // shifter after consuming w_cur_bit
  logic             w_last;      // final bit of the word is on the line
  logic             w_accept;    // handshake completes at the next edge
  logic             w_word_done; // final bit consumed at the next edge

  // The outgoing bit always sits at one end of the register; the direction
  // parameter only decides which end and which way the remainder moves.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_cur_bit = shreg_q[WIDTH-1];
      assign w_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_cur_bit = shreg_q[0];
      assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SER_PARITY_EN
  // With parity the word boundary is the parity bit, not the last data bit.
  assign w_last = (state_q == c_st_par);
`else
  assign w_last = (state_q == c_st_shift) && (bcnt_q == '0);
`endif

  // Ready opens on the final bit when it is being consumed, so the next word
  // loads on the same edge and the serial stream has no bubble.
  assign s_ready     = (state_q == c_st_idle) || (w_last && bit_en);
  assign w_accept    = s_valid && s_ready;
  assign w_word_done = w_last && bit_en;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    word_cnt_d = word_cnt_q;
`ifdef SER_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      c_st_idle: begin
        // bit_en has no effect here; only an accept leaves IDLE.
      end

      c_st_shift: begin
        if (bit_en) begin
          if (bcnt_q == '0) begin
`ifdef SER_PARITY_EN
            state_d = c_st_par;
`else
            state_d = c_st_idle;
            shreg_d = '0;
`endif
          end else begin
            shreg_d = w_shifted;
            bcnt_d  = bcnt_q - c_bcnt_one;
          end
        end
      end

`ifdef SER_PARITY_EN
      c_st_par: begin
        if (bit_en) begin
          state_d = c_st_idle;
          shreg_d = '0;
        end
      end
`endif

      default: begin
        state_d = c_st_idle;
        shreg_d = '0;
        bcnt_d  = '0;
      end
    endcase

    if (w_word_done) begin
      word_cnt_d = word_cnt_q + c_wcnt_one;
    end

    // An accept takes priority over the return to IDLE: it can only happen
    // from IDLE or on the very edge that retires the previous word.
    if (w_accept) begin
      state_d  = c_st_shift;
      shreg_d  = s_data;
      bcnt_d   = c_bcnt_load;
`ifdef SER_PARITY_EN
      parity_d = ^s_data;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= c_st_idle;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      word_cnt_q <= '0;
`ifdef SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      word_cnt_q <= word_cnt_d;
`ifdef SER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so an asynchronous reset
  // drops the line to idle immediately and bit_en=0 holds them unchanged.
  // --------------------------------------------------------------------------
  assign ser_valid = (state_q != c_st_idle);
  assign ser_last  = w_last;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    ser_out = IDLE_LEVEL;
    if (state_q == c_st_shift) begin
      ser_out = w_cur_bit;
    end
`ifdef SER_PARITY_EN
    if (state_q == c_st_par) begin
      ser_out = parity_q;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench for bit_serializer. Three instances share
//            one stimulus: default (MSB first), LSB first, and CNT_W=2 for
//            counter wrap. Table-driven vectors plus hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

  logic       clk;
  logic       rstn;
  logic       s_valid;
  logic [7:0] s_data;
  logic       bit_en;

  logic        s_ready,   ser_out,   ser_valid,   ser_last;
  logic [15:0] word_cnt;
  logic        l_s_ready, l_ser_out, l_ser_valid, l_ser_last;
  logic [15:0] l_word_cnt;
  logic        c_s_ready, c_ser_out, c_ser_valid, c_ser_last;
  logic [1:0]  c_word_cnt;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .CNT_W(16), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bit_en(bit_en), .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last),
    .word_cnt(word_cnt));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .CNT_W(16), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(l_s_ready), .s_data(s_data),
    .bit_en(bit_en), .ser_out(l_ser_out), .ser_valid(l_ser_valid), .ser_last(l_ser_last),
    .word_cnt(l_word_cnt));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .CNT_W(2), .IDLE_LEVEL(1'b0)) dut_c2 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(c_s_ready), .s_data(s_data),
    .bit_en(bit_en), .ser_out(c_ser_out), .ser_valid(c_ser_valid), .ser_last(c_ser_last),
    .word_cnt(c_word_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic        en;
    logic        e_out;
    logic        e_val;
    logic        e_last;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic e,
                     input logic o, input logic val, input logic l, input logic rdy,
                     input logic [15:0] c);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.en = e;
    x.e_out = o; x.e_val = val; x.e_last = l; x.e_rdy = rdy; x.e_cnt = c;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; s_valid = 1'b0; bit_en = 1'b0; s_data = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Offer one word with bit_en held high, then wait for the line to go idle.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; bit_en = 1'b1;
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("send_ready_timeout", 0, 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n = 0;
    while (ser_valid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("send_idle_timeout", 0, 32'(ser_valid), 32'd0);
  endtask

  // Watchdog: the bench must always end by itself.
  initial begin
    #400000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hist;
    int         det;
    logic [7:0] seq8;
    int         nval;

    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; bit_en = 1'b0;
    hist = 4'b0; det = 0;

`ifndef SER_PARITY_EN
    // ---------------- vector table ------------------------------------------
    //  rst vld data  en | out val last rdy cnt
    // Single word 8'hB0, bit_en constant high
    add(1, 0, 8'h00, 0,   0, 0, 0, 1, 0);   // reset state
    add(0, 1, 8'hB0, 1,   0, 0, 0, 1, 0);   // accept
    add(0, 0, 8'h00, 1,   1, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   1, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   1, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1,   0, 1, 1, 1, 0);   // 8th bit: last, ready opens
    add(0, 0, 8'h00, 1,   0, 0, 0, 1, 1);   // idle, one word sent
    add(0, 0, 8'h00, 0,   0, 0, 0, 1, 1);   // bit_en low in idle: no effect
    // Back-to-back 8'hB0 then 8'hFF
    add(1, 0, 8'h00, 0,   0, 0, 0, 1, 0);
    add(0, 1, 8'hB0, 1,   0, 0, 0, 1, 0);
    add(0, 1, 8'hFF, 1,   1, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   0, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   1, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   1, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   0, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   0, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   0, 1, 0, 0, 0);
    add(0, 1, 8'hFF, 1,   0, 1, 1, 1, 0);   // 8th bit: FF loads here
    for (int k = 0; k < 7; k++)
      add(0, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    add(0, 0, 8'h00, 1,   1, 1, 1, 1, 1);   // 16th bit
    add(0, 0, 8'h00, 1,   0, 0, 0, 1, 2);   // idle, two words sent

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rstn    = ~tbl[i].rst;
      s_valid = tbl[i].vld;
      s_data  = tbl[i].data;
      bit_en  = tbl[i].en;
      #1;
      chk("tbl_ser_out",   i, 32'(ser_out),   32'(tbl[i].e_out));
      chk("tbl_ser_valid", i, 32'(ser_valid), 32'(tbl[i].e_val));
      chk("tbl_ser_last",  i, 32'(ser_last),  32'(tbl[i].e_last));
      chk("tbl_s_ready",   i, 32'(s_ready),   32'(tbl[i].e_rdy));
      chk("tbl_word_cnt",  i, 32'(word_cnt),  32'(tbl[i].e_cnt));
      // Downstream 1011 detector on consumed bits
      if (tbl[i].rst) hist = 4'b0;
      else if (ser_valid && bit_en) begin
        hist = {hist[2:0], ser_out};
        if (hist == 4'b1011) det++;
      end
    end
    // One detection per 8'hB0 word; FF adds none.
    chk("det_1011", 0, 32'(det), 32'd2);

    // ---------------- strobe gating, 8'hA5 ----------------------------------
    pulse_reset();
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hA5; bit_en = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    seq8 = 8'b1010_0101;
    nval = 0;
    for (int j = 0; j < 24; j++) begin
      bit_en = (j % 3 == 2);
      #1;
      if (ser_valid) nval++;
      chk("strobe_out",   j, 32'(ser_out),  32'(seq8[7 - j/3]));
      chk("strobe_last",  j, 32'(ser_last), 32'(j >= 21));
      chk("strobe_ready", j, 32'(s_ready),  32'(j == 23));
      @(negedge clk);
    end
    bit_en = 1'b0;
    #1;
    chk("strobe_valid_end", 0, 32'(ser_valid), 32'd0);
    chk("strobe_nvalid",    0, 32'(nval),      32'd24);
    chk("strobe_cnt",       0, 32'(word_cnt),  32'd1);

    // ---------------- LSB first, 8'h0D --------------------------------------
    pulse_reset();
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h0D; bit_en = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    seq8 = 8'b1011_0000;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("lsb_out",   j, 32'(l_ser_out),   32'(seq8[7 - j]));
      chk("lsb_valid", j, 32'(l_ser_valid), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("lsb_valid_end", 0, 32'(l_ser_valid), 32'd0);
    chk("lsb_cnt",       0, 32'(l_word_cnt),  32'd1);
`else
    // ---------------- parity, 8'h07 -----------------------------------------
    begin
      logic [8:0] pseq;
      pulse_reset();
      @(negedge clk);
      #1;
      chk("par_reset_ready", 0, 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_data = 8'h07; bit_en = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      pseq = 9'b0_0000_1111;
      for (int j = 0; j < 9; j++) begin
        #1;
        chk("par_out",   j, 32'(ser_out),   32'(pseq[8 - j]));
        chk("par_valid", j, 32'(ser_valid), 32'd1);
        chk("par_last",  j, 32'(ser_last),  32'(j == 8));
        chk("par_ready", j, 32'(s_ready),   32'(j == 8));
        chk("par_cnt",   j, 32'(word_cnt),  32'd0);
        @(negedge clk);
      end
      #1;
      chk("par_valid_end", 0, 32'(ser_valid), 32'd0);
      chk("par_cnt_end",   0, 32'(word_cnt),  32'd1);
    end
`endif

    // ---------------- asynchronous reset mid-word ---------------------------
    pulse_reset();
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hB0; bit_en = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_pre_valid", 0, 32'(ser_valid), 32'd1);
    chk("midrst_pre_out",   0, 32'(ser_out),   32'd1);   // 4th bit of B0
    #2;
    rstn = 1'b0;
    #1;   // well before the next rising edge
    chk("midrst_valid", 0, 32'(ser_valid), 32'd0);
    chk("midrst_out",   0, 32'(ser_out),   32'd0);
    chk("midrst_last",  0, 32'(ser_last),  32'd0);
    chk("midrst_cnt",   0, 32'(word_cnt),  32'd0);
    @(negedge clk);
    bit_en = 1'b0;
    rstn = 1'b1;
    #1;
    chk("midrst_rel_ready", 0, 32'(s_ready),   32'd1);
    chk("midrst_rel_valid", 0, 32'(ser_valid), 32'd0);
    chk("midrst_rel_cnt",   0, 32'(word_cnt),  32'd0);

    // ---------------- counter wrap with CNT_W=2 -----------------------------
    pulse_reset();
    send_word(8'h12);
    send_word(8'h34);
    send_word(8'h56);
    chk("wrap_c2_3",  0, 32'(c_word_cnt), 32'd3);
    chk("wrap_dut_3", 0, 32'(word_cnt),   32'd3);
    send_word(8'h78);
    chk("wrap_c2_4",  0, 32'(c_word_cnt), 32'd0);
    chk("wrap_dut_4", 0, 32'(word_cnt),   32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
